fetch_decode_stage: RTL and testbench

- Instruction fetch unit plus IF/ID pipeline register for the cache-backed processor.
- Generates the PC and requests instructions from the set-associative instruction cache, tolerating hit/miss latency.
- Registers the fetched word and splits it into decode fields. id_imm[9:0] feeds the immediate sign-extension stage directly downstream.
- Handles downstream stall with a one-entry pending buffer, and handles branch redirect with squash of in-flight misses.

---
 rtl/fetch_decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Instruction fetch unit with IF/ID pipeline register.
// Drives the PC into the instruction cache and tolerates hit/miss latency.
// A one-entry pending buffer absorbs a fill that returns while decode is stalled.
// Branch redirects squash any in-flight miss so that its data never reaches decode.
// Handshake: icache_req/icache_addr form a request that the cache completes by
// raising icache_ready with icache_rdata in the same cycle. While icache_req=1
// and icache_ready=0, the address is held and the request is never withdrawn.
// Decode side: stall=1 while id_valid=1 means the IF/ID register must hold.
module fetch_decode_stage #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                icache_req,
    output logic [PC_WIDTH-1:0] icache_addr,
    input  logic                icache_ready,
    input  logic [31:0]         icache_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [5:0]          id_opcode,
    output logic [4:0]          id_rd,
    output logic [4:0]          id_rs,
    output logic [4:0]          id_rt,
    output logic [9:0]          id_imm,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] sq_addr_q, sq_addr_d;
    logic                pend_valid_q, pend_valid_d;
    logic [31:0]         pend_instr_q, pend_instr_d;
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                id_valid_q, id_valid_d;
    logic [31:0]         id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;

    logic                can_load;
    logic                load;
    logic [31:0]         load_instr;
    logic [PC_WIDTH-1:0] load_pc;

    assign can_load = !(stall && id_valid_q);

    // Next-state, cache request and IF/ID load selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sq_addr_d    = sq_addr_q;
        pend_valid_d = pend_valid_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        icache_req   = 1'b0;
        icache_addr  = pc_q;
        load         = 1'b0;
        load_instr   = icache_rdata;
        load_pc      = pc_q;

        case (state_q)
            ST_FETCH: begin
                // A buffered fill drains first; the next request goes out once it is empty.
                icache_req = can_load && !pend_valid_q;
                if (pend_valid_q && can_load) begin
                    load         = 1'b1;
                    load_instr   = pend_instr_q;
                    load_pc      = pend_pc_q;
                    pend_valid_d = 1'b0;
                end else if (icache_req) begin
                    if (icache_ready) begin
                        load = 1'b1;
                        pc_d = pc_q + STEP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                icache_req = 1'b1;
                if (icache_ready) begin
                    if (can_load) begin
                        load = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_instr_d = icache_rdata;
                        pend_pc_d    = pc_q;
                    end
                    pc_d    = pc_q + STEP;
                    state_d = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                // pc_q already holds the redirect target; only the old address is replayed.
                icache_req  = 1'b1;
                icache_addr = sq_addr_q;
                if (icache_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (redirect_valid) begin
            // Redirect beats stall: flush IF/ID and the buffer, keep the instruction fields.
            id_valid_d   = 1'b0;
            pend_valid_d = 1'b0;
            pc_d         = redirect_pc;
            if (icache_req && !icache_ready) begin
                state_d   = ST_SQUASH;
                sq_addr_d = icache_addr;
            end else begin
                state_d = ST_FETCH;
            end
        end else if (load) begin
            id_valid_d = 1'b1;
            id_instr_d = load_instr;
            id_pc_d    = load_pc;
        end else if (!stall) begin
            id_valid_d = 1'b0;
        end

        if (reset) begin
            icache_req = 1'b0;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            sq_addr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_instr_q <= '0;
            pend_pc_q    <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sq_addr_q    <= sq_addr_d;
            pend_valid_q <= pend_valid_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[31:26];
    assign id_rd     = id_instr_q[25:21];
    assign id_rs     = id_instr_q[20:16];
    assign id_rt     = id_instr_q[15:11];
    assign id_imm    = id_instr_q[9:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a transaction-level model of the fetch
// unit is checked every cycle, plus hand-computed literal expectations.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [9:0]  id_imm;
    logic [1:0]  dbg_state;

    logic        ovr = 1'b0;
    logic [31:0] ovr_data = '0;
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Clock.
    always #5 clk = ~clk;

    // Cache data: address tagged with 0xA0000000 unless a directed word is forced.
    assign icache_rdata = ovr ? ovr_data : (icache_addr | 32'hA000_0000);

    fetch_decode_stage dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ready(icache_ready), .icache_rdata(icache_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_imm(id_imm), .dbg_state(dbg_state)
    );

    // Model: one outstanding request (live or dead), a queue of buffered fills, IF/ID contents.
    logic [31:0] m_pc = '0;
    logic [31:0] m_old = '0;
    bit          m_busy = 1'b0;
    bit          m_dead = 1'b0;
    bit          m_idv = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_idpc = '0;
    logic [63:0] m_pend[$];

    function automatic bit exp_req();
        if (reset) return 1'b0;
        if (m_busy) return 1'b1;
        return !(stall && m_idv) && (m_pend.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return (m_busy && m_dead) ? m_old : m_pc;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_busy && m_dead) return 2'd2;
        if (m_busy) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin
        bit          req;
        bit          accept;
        bit          load;
        logic [63:0] ent;
        req    = exp_req();
        accept = !(stall && m_idv);
        load   = 1'b0;
        ent    = '0;
        if (reset) begin
            m_pc = 32'h0; m_old = '0; m_busy = 0; m_dead = 0;
            m_idv = 0; m_instr = '0; m_idpc = '0; m_pend.delete();
        end else if (redirect_valid) begin
            if (req && !icache_ready) begin
                m_old  = exp_addr();
                m_busy = 1; m_dead = 1;
            end else begin
                m_busy = 0; m_dead = 0;
            end
            m_pc  = redirect_pc;
            m_idv = 0;
            m_pend.delete();
        end else begin
            if (m_busy) begin
                if (icache_ready) begin
                    if (!m_dead) begin
                        if (accept) begin load = 1; ent = {icache_rdata, m_pc}; end
                        else m_pend.push_back({icache_rdata, m_pc});
                        m_pc = m_pc + 32'd4;
                    end
                    m_busy = 0; m_dead = 0;
                end
            end else if (m_pend.size() > 0 && accept) begin
                load = 1;
                ent  = m_pend.pop_front();
            end else if (req) begin
                if (icache_ready) begin
                    load = 1; ent = {icache_rdata, m_pc};
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_busy = 1;
                end
            end
            if (load) begin
                m_idv = 1; m_instr = ent[63:32]; m_idpc = ent[31:0];
            end else if (!stall) begin
                m_idv = 0;
            end
        end
    end

    // Per-cycle compare against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit er;
            er = exp_req();
            check("icache_req", {63'd0, icache_req}, {63'd0, er});
            if (er) check("icache_addr", {32'd0, icache_addr}, {32'd0, exp_addr()});
            check("id_valid", {63'd0, id_valid}, {63'd0, m_idv});
            check("id_instr", {32'd0, id_instr}, {32'd0, m_instr});
            check("id_pc", {32'd0, id_pc}, {32'd0, m_idpc});
            check("id_opcode", {58'd0, id_opcode}, {58'd0, m_instr[31:26]});
            check("id_rd", {59'd0, id_rd}, {59'd0, m_instr[25:21]});
            check("id_rs", {59'd0, id_rs}, {59'd0, m_instr[20:16]});
            check("id_rt", {59'd0, id_rt}, {59'd0, m_instr[15:11]});
            check("id_imm", {54'd0, id_imm}, {54'd0, m_instr[9:0]});
            check("state", {62'd0, dbg_state}, {62'd0, exp_state()});
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of inputs, then let combinational outputs settle.
    task automatic cyc(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc,
                       input bit ov, input logic [31:0] od);
        icache_ready   = rdy;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        ovr            = ov;
        ovr_data       = od;
        #1;
    endtask

    // Literal-check helper for 32-bit values.
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {32'd0, act}, {32'd0, exp});
    endtask

    // Directed sequence.
    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and back-to-back hits.
        cyc(1, 0, 0, 0, 0, 0);
        lit("rst_req", {31'd0, icache_req}, 1); lit("rst_addr", icache_addr, 32'h0);
        lit("rst_valid", {31'd0, id_valid}, 0); lit("rst_instr", id_instr, 0);
        lit("rst_state", {30'd0, dbg_state}, 0);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("hit_addr4", icache_addr, 32'h4); lit("hit_pc0", id_pc, 32'h0);
        lit("hit_instr0", id_instr, 32'hA000_0000); lit("hit_valid", {31'd0, id_valid}, 1);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("hit_addr8", icache_addr, 32'h8); lit("hit_pc4", id_pc, 32'h4);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("hit_addrC", icache_addr, 32'hC); lit("hit_pc8", id_pc, 32'h8);

        // Miss at 0x10 held for three cycles.
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("miss_addr", icache_addr, 32'h10); lit("miss_pcC", id_pc, 32'hC);
        for (int i = 0; i < 2; i++) begin
            adv(); cyc(0, 0, 0, 0, 0, 0);
            lit("miss_hold_addr", icache_addr, 32'h10); lit("miss_hold_req", {31'd0, icache_req}, 1);
            lit("miss_valid0", {31'd0, id_valid}, 0); lit("miss_state", {30'd0, dbg_state}, 1);
        end
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("miss_ret_addr", icache_addr, 32'h10);

        // Stall with a valid instruction: hold and issue nothing.
        adv(); cyc(1, 1, 0, 0, 0, 0);
        lit("stall_valid", {31'd0, id_valid}, 1); lit("stall_pc", id_pc, 32'h10);
        lit("stall_instr", id_instr, 32'hA000_0010); lit("stall_req", {31'd0, icache_req}, 0);
        adv(); cyc(0, 1, 0, 0, 0, 0);
        lit("stall_hold_pc", id_pc, 32'h10); lit("stall_hold_req", {31'd0, icache_req}, 0);
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("resume_addr", icache_addr, 32'h14);
        adv(); cyc(1, 1, 0, 0, 1, 32'h1234_5678);
        lit("fill_addr", icache_addr, 32'h14); lit("fill_valid0", {31'd0, id_valid}, 0);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("fill_instr", id_instr, 32'h1234_5678); lit("fill_pc", id_pc, 32'h14);
        lit("next_addr", icache_addr, 32'h18);
        adv(); cyc(1, 0, 0, 0, 0, 0);

        // Miss at 0x20, redirect twice while squashing.
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("rd_miss_addr", icache_addr, 32'h20);
        adv(); cyc(0, 0, 1, 32'h200, 0, 0);
        adv(); cyc(0, 0, 1, 32'h100, 0, 0);
        lit("sq_state", {30'd0, dbg_state}, 2); lit("sq_addr", icache_addr, 32'h20);
        lit("sq_valid", {31'd0, id_valid}, 0);
        adv(); cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        lit("sq_ret_addr", icache_addr, 32'h20);
        adv(); cyc(1, 0, 0, 0, 1, 32'hFC21_83FF);
        lit("rd_addr", icache_addr, 32'h100); lit("rd_valid0", {31'd0, id_valid}, 0);
        lit("rd_state", {30'd0, dbg_state}, 0);

        // Field split.
        adv(); cyc(1, 0, 0, 0, 1, 32'h0000_0155);
        lit("f_opcode", {26'd0, id_opcode}, 32'h3F); lit("f_rd", {27'd0, id_rd}, 32'h01);
        lit("f_rs", {27'd0, id_rs}, 32'h01); lit("f_rt", {27'd0, id_rt}, 32'h10);
        lit("f_imm", {22'd0, id_imm}, 32'h3FF); lit("f_pc", id_pc, 32'h100);

        // Redirect on a hit cycle, then PC wrap.
        adv(); cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        lit("f_imm155", {22'd0, id_imm}, 32'h155); lit("f_pc104", id_pc, 32'h104);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        lit("wrap_valid0", {31'd0, id_valid}, 0); lit("wrap_addr", icache_addr, 32'hFFFF_FFFC);
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("wrap_pc", id_pc, 32'hFFFF_FFFC); lit("wrap_next", icache_addr, 32'h0);
        adv(); cyc(0, 0, 0, 0, 0, 0);

        // Reset mid-miss with a stray ready carrying stale data.
        reset = 1'b1;
        cyc(1, 0, 0, 0, 1, 32'hBAD0_BAD0);
        lit("rst_mid_req", {31'd0, icache_req}, 0);
        adv();
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        lit("rst2_valid", {31'd0, id_valid}, 0); lit("rst2_addr", icache_addr, 32'h0);
        lit("rst2_state", {30'd0, dbg_state}, 0); lit("rst2_instr", id_instr, 32'h0);
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("rst2_stale", {31'd0, id_valid}, 0);
        adv(); cyc(1, 0, 0, 0, 0, 0);
        adv(); cyc(0, 0, 0, 0, 0, 0);
        lit("rst2_pc", id_pc, 32'h0); lit("rst2_instr_ok", id_instr, 32'hA000_0000);
        lit("rst2_valid1", {31'd0, id_valid}, 1);
        adv();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
